// File: rtl/ddc_pingpong_ctrl.sv
// Ping-pong sample buffer controller between the DDC word stream and the per-PRI framer.
// Define DDC_PP_DROPCNT_EN to add the saturating drop_cnt output (overruns plus timeouts).
module ddc_pingpong_ctrl #(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 11100,
    parameter int TO_SLACK  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pri,
    input  logic [127:0]      din,
    input  logic              din_valid,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [127:0]      wr_data,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              frm_rd,
    input  logic [ADDR_W-1:0] frm_addr,
    input  logic              frm_last,
    output logic              frm_enable,
    output logic              frm_pri,
    output logic [15:0]       frm_length,
    output logic              overrun,
    output logic              wr_ovf,
    output logic              timeout
`ifdef DDC_PP_DROPCNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                pri_meta_r;
    logic                pri_sync_r;
    logic                pri_dly_r;
    logic                pri_edge_s;
    logic [17:0]         wd_r;
    logic [15:0]         wr_cnt_r;
    logic                wr_en_r;
    logic                wr_bank_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [127:0]        wr_data_r;
    logic                wr_ovf_r;
    logic                rd_en_r;
    logic                rd_bank_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                frm_enable_r;
    logic                frm_pri_r;
    logic [15:0]         frm_length_r;
    logic                overrun_r;
    logic                timeout_r;
    logic                active_s;
    logic                swap_s;
    logic                ovr_s;
    logic                to_s;
    logic                wb_nxt_s;
    logic [15:0]         cnt_base_s;
    logic                wr_ok_s;

    assign pri_edge_s = pri_sync_r & ~pri_dly_r;

    // PRI synchronizer and edge register
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_meta_r <= 1'b0;
            pri_sync_r <= 1'b0;
            pri_dly_r  <= 1'b0;
        end else begin
            pri_meta_r <= pri;
            pri_sync_r <= pri_meta_r;
            pri_dly_r  <= pri_sync_r;
        end
    end

    // FSM state register and framer watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            wd_r    <= 18'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_START) begin
                wd_r <= {1'b0, frm_length_r, 1'b0} + 18'(TO_SLACK);
            end else if ((state_r == S_BUSY) && (wd_r != 18'd0)) begin
                wd_r <= wd_r - 18'd1;
            end else begin
                wd_r <= wd_r;
            end
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pri_edge_s && (wr_cnt_r != 16'd0)) state_nxt_s = S_START;
                else                                   state_nxt_s = S_IDLE;
            end
            S_START: state_nxt_s = S_BUSY;
            S_BUSY: begin
                if (frm_last || (wd_r <= 18'd1)) state_nxt_s = S_IDLE;
                else                             state_nxt_s = S_BUSY;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM event decode: swap, overrun, timeout and the write slot of the current word
    always_comb begin
        active_s = (state_r == S_START) || (state_r == S_BUSY);
        swap_s   = (state_r == S_IDLE) && pri_edge_s && (wr_cnt_r != 16'd0);
        ovr_s    = active_s && pri_edge_s;
        to_s     = (state_r == S_BUSY) && !frm_last && (wd_r <= 18'd1);
        if (swap_s) wb_nxt_s = ~wr_bank_r;
        else        wb_nxt_s = wr_bank_r;
        // A word arriving with the PRI edge belongs to the new PRI
        if (swap_s || ovr_s) cnt_base_s = 16'd0;
        else                 cnt_base_s = wr_cnt_r;
        wr_ok_s = din_valid && (cnt_base_s < 16'(MAX_WORDS));
    end

    // Write port, word counter and write-overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_bank_r <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 128'd0;
            wr_cnt_r  <= 16'd0;
            wr_ovf_r  <= 1'b0;
        end else begin
            wr_bank_r <= wb_nxt_s;
            wr_en_r   <= wr_ok_s;
            if (wr_ok_s) begin
                wr_addr_r <= ADDR_W'(cnt_base_s);
                wr_data_r <= din;
                wr_cnt_r  <= cnt_base_s + 16'd1;
                wr_ovf_r  <= wr_ovf_r;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
                wr_cnt_r  <= cnt_base_s;
                wr_ovf_r  <= wr_ovf_r | din_valid;
            end
        end
    end

    // Read port, framer control and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_r      <= 1'b0;
            rd_bank_r    <= 1'b1;
            rd_addr_r    <= '0;
            frm_enable_r <= 1'b0;
            frm_pri_r    <= 1'b0;
            frm_length_r <= 16'd0;
            overrun_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            rd_en_r      <= frm_rd && active_s;
            rd_addr_r    <= (frm_rd && active_s) ? frm_addr : rd_addr_r;
            rd_bank_r    <= swap_s ? wr_bank_r : rd_bank_r;
            frm_length_r <= swap_s ? wr_cnt_r : frm_length_r;
            frm_pri_r    <= (state_nxt_s == S_START);
            frm_enable_r <= ~to_s;
            overrun_r    <= overrun_r | ovr_s;
            timeout_r    <= timeout_r | to_s;
        end
    end

`ifdef DDC_PP_DROPCNT_EN
    logic [15:0] drop_cnt_r;
    logic [1:0]  drop_inc_s;

    assign drop_inc_s = {1'b0, ovr_s} + {1'b0, to_s};

    // Saturating count of overrun and timeout events
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_cnt_r > (16'hFFFF - {14'd0, drop_inc_s})) begin
            drop_cnt_r <= 16'hFFFF;
        end else begin
            drop_cnt_r <= drop_cnt_r + {14'd0, drop_inc_s};
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign wr_en      = wr_en_r;
    assign wr_bank    = wr_bank_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign rd_en      = rd_en_r;
    assign rd_bank    = rd_bank_r;
    assign rd_addr    = rd_addr_r;
    assign frm_enable = frm_enable_r;
    assign frm_pri    = frm_pri_r;
    assign frm_length = frm_length_r;
    assign overrun    = overrun_r;
    assign wr_ovf     = wr_ovf_r;
    assign timeout    = timeout_r;

endmodule

// File: doc/ddc_pingpong_ctrl.md
# ddc_pingpong_ctrl

Ping-pong buffer controller between the DDC sample stream and the per-PRI frame builder. It writes packed DDC words into one bank of a two-bank sample RAM while the framer drains the other bank. On each PRI rising edge it swaps the banks and starts the framer with the captured length. It also detects overruns, saturates overflows and recovers from a stalled framer.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word address width per bank.
- `MAX_WORDS`, 11100: bank capacity in 128-bit words.
- `TO_SLACK`, 16: extra cycles added to the framer watchdog limit.

Ports:
- `clk` in 1: user clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pri` in 1: PRI pulse, asynchronous to `clk`.
- `din` in 128: four packed I/Q pairs, `{I1,Q1,I2,Q2,I3,Q3,I4,Q4}`.
- `din_valid` in 1: `din` qualifier.
- `wr_en` out 1, `wr_bank` out 1, `wr_addr` out ADDR_W, `wr_data` out 128: RAM write port.
- `rd_en` out 1, `rd_bank` out 1, `rd_addr` out ADDR_W: RAM read port, driven from the framer's request.
- `frm_rd` in 1, `frm_addr` in ADDR_W: framer RAM read request.
- `frm_last` in 1: framer end-of-frame beat.
- `frm_enable` out 1: framer enable.
- `frm_pri` out 1: framer start pulse.
- `frm_length` out 16: word count for the framer.
- `overrun` out 1: sticky flag.
- `wr_ovf` out 1: sticky flag.
- `timeout` out 1: sticky flag.

## Operation
- PRI edge detection:
  - `pri` passes through a 2-FF synchronizer plus one edge register.
  - `pri_edge` is asserted on a synchronized 0→1 transition.
- Write side:
  - `wr_cnt` (16 bit) counts words in the current write bank `wb`.
  - On `din_valid` with `wr_cnt < MAX_WORDS`: `wr_addr=wr_cnt`, `wr_data=din`, `wr_en=1`, then `wr_cnt++`.
  - At `wr_cnt == MAX_WORDS`: the word is dropped and `wr_ovf` is set.
- Read-side FSM, states IDLE, START, BUSY:
  - IDLE, on `pri_edge` with `wr_cnt > 0`:
    - toggle `wb`; `rd_bank` takes the old `wb`;
    - `frm_length = wr_cnt`; clear `wr_cnt`; go to START.
  - START: `frm_pri=1` for exactly one cycle; load watchdog with `2*frm_length+TO_SLACK`; go to BUSY.
  - BUSY: on `frm_last`, go to IDLE. On watchdog reaching 0: set `timeout`, drive `frm_enable=0` for one cycle, go to IDLE.
- `pri_edge` with `wr_cnt == 0`: no swap, no start, state unchanged.
- `pri_edge` while in START or BUSY (overrun):
  - set `overrun`;
  - no swap; clear `wr_cnt` so the write bank is overwritten from address 0;
  - the in-progress read is undisturbed.
- Simultaneous `pri_edge` and `din_valid`: the word belongs to the new PRI, written at address 0 of the new `wb` (or the same bank if overrun).
- Simultaneous `pri_edge` and `frm_last` in BUSY: counted as overrun; the FSM goes to IDLE. The next edge swaps normally.
- Read port: `rd_en=frm_rd`, `rd_addr=frm_addr`, registered one cycle; `rd_bank` is held stable for the whole read.
- Outside START/BUSY, `frm_rd` is ignored and `rd_en=0`.
- `frm_enable=1` at all times after reset, except the one-cycle timeout flush.

## Timing
- Reset values:
  - `wr_en=0`, `wr_bank=0`, `wr_addr=0`, `wr_data=0`;
  - `rd_en=0`, `rd_bank=1`, `rd_addr=0`;
  - `frm_enable=0` during reset, 1 from the first cycle after;
  - `frm_pri=0`, `frm_length=0`;
  - `overrun=0`, `wr_ovf=0`, `timeout=0`;
  - FSM in IDLE, `wr_cnt=0`.
- `pri` rising to `pri_edge`: 3 cycles. `pri_edge` to `frm_pri`: 2 cycles (swap cycle, then START).
- `din_valid` to `wr_en`: 1 cycle. `frm_rd` to `rd_en`: 1 cycle.
- `rst` mid-frame: all state returns to reset values on the next edge. The framer is flushed because `frm_enable=0` during reset.
- Sticky flags clear only on `rst`.

## Configuration
- `DDC_PP_DROPCNT_EN` defined:
  - adds output `drop_cnt` (16 bit), counting overrun events plus timeouts;
  - saturates at 0xFFFF; reset 0.
- Undefined: the port and counter are absent; the flags are unchanged.

## Test plan
- Reset then 5 `din_valid` words A0..A4, then `pri`:
  - writes at bank0 addresses 0..4;
  - `frm_pri` pulses once; `frm_length=5`; `rd_bank=0`; `wr_bank=1`.
- Framer reads addr 3 while 2 words are written:
  - `rd_en` with `rd_bank=0`, `rd_addr=3`;
  - `wr_en` with `wr_bank=1`, `wr_addr` 0,1;
  - no interference between the two ports.
- Second `pri` before `frm_last`:
  - `overrun=1`; no swap; next write lands at bank1 address 0;
  - the read continues to `frm_last`; FSM returns to IDLE.
- 11101 words within one PRI:
  - last write at address 11099; `wr_ovf=1`;
  - next `pri` gives `frm_length=11100`.
- Start with `frm_length=4` and never assert `frm_last`:
  - after 24 BUSY cycles, `timeout=1` and `frm_enable=0` for one cycle;
  - FSM returns to IDLE and the next `pri` starts normally.
- `pri` with no data written: no `frm_pri` and no bank swap. `rst` mid-BUSY: all outputs return to reset values.
